// File: rtl/serial_reg_loader_pkg.sv
// Shared definitions for the bit-serial register loader and the register bank
// it feeds: frame state encoding, default geometry and a small sizing helper.
package serial_reg_loader_pkg;

  // Frame progress: waiting for a start bit, collecting address bits,
  // collecting data bits, and the single write-strobe cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADDR   = 2'd1,
    DATA   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  // Default register-word geometry, also used by the register bank.
  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_ADDR_W = 3;

  // Larger of two sizes; used to size the shared address/data bit counter.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/serial_reg_loader_ser_shift_reg.sv
// MSB-first shift register with synchronous clear and a snapshot register.
// The working register assembles the field bit by bit; the snapshot register
// is only updated on load, so its output never shows a partially shifted value.
module ser_shift_reg
  import serial_reg_loader_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift,
  input  logic             din,
  input  logic             load,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] hold
);

  logic [WIDTH-1:0] nxt;

  // Value after shifting din in at the LSB end.
  generate
    if (WIDTH == 1) begin : g_one
      always_comb nxt = din;
    end else begin : g_multi
      always_comb nxt = {q[WIDTH-2:0], din};
    end
  endgenerate

  // Working register: clear alone empties it; clear with shift starts a new
  // field with din as its first (eventually most significant) bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr && shift) begin
      q <= WIDTH'(din);
    end else if (clr) begin
      q <= '0;
    end else if (shift) begin
      q <= nxt;
    end
  end

  // Snapshot register: a load coinciding with the final shift captures the
  // completed value directly so it is visible one cycle after the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold <= '0;
    end else if (load) begin
      hold <= shift ? nxt : q;
    end
  end

endmodule

// File: rtl/serial_reg_loader.sv
// Bit-serial front end for the register bank. Collects an address-then-data
// frame one bit per handshake beat (MSB first) and issues a one-cycle write
// strobe with the assembled address and word.
module serial_reg_loader
  import serial_reg_loader_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              SerIn,
  input  logic              SerValid,
  input  logic              SerStart,
  output logic              SerReady,
  output logic              WrEn,
  output logic [ADDR_W-1:0] WrAddr,
  output logic [WIDTH-1:0]  WrData,
  output logic              Busy,
  output logic              FrameErr
);

  localparam int unsigned CNT_MAX = max_u(ADDR_W, WIDTH);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] ADDR_RELOAD = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_RELOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  logic beat;
  logic start_load;
  logic addr_shift;
  logic data_shift;
  logic commit_load;
  logic restart;

  logic             wr_en_q;
  logic             frame_err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WIDTH-1:0]  data_q;

  assign SerReady = (state != COMMIT);
  assign Busy     = (state != IDLE);
  assign beat     = SerValid & SerReady;
  assign WrEn     = wr_en_q;
  assign FrameErr = frame_err_q;

  // State register and remaining-bit counter.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state, counter and shift/commit control decode.
  // A start-flagged beat in ADDR or DATA is handled exactly like a start in
  // IDLE plus an error flag, so a restart on the final data beat never
  // reaches COMMIT.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    start_load  = 1'b0;
    addr_shift  = 1'b0;
    data_shift  = 1'b0;
    commit_load = 1'b0;
    restart     = 1'b0;

    unique case (state)
      IDLE, ADDR, DATA: begin
        if (beat && SerStart) begin
          start_load = 1'b1;
          restart    = (state != IDLE);
          if (ADDR_W > 1) begin
            state_n = ADDR;
            cnt_n   = ADDR_RELOAD;
          end else begin
            state_n = DATA;
            cnt_n   = DATA_RELOAD;
          end
        end else if (beat && (state == ADDR)) begin
          addr_shift = 1'b1;
          if (cnt == CNT_LAST) begin
            state_n = DATA;
            cnt_n   = DATA_RELOAD;
          end else begin
            cnt_n = cnt - CNT_LAST;
          end
        end else if (beat && (state == DATA)) begin
          data_shift = 1'b1;
          if (cnt == CNT_LAST) begin
            state_n     = COMMIT;
            cnt_n       = '0;
            commit_load = 1'b1;
          end else begin
            cnt_n = cnt - CNT_LAST;
          end
        end
      end
      COMMIT: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Registered strobe and abort pulse, both asserted for the cycle after
  // the beat that caused them.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_en_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wr_en_q     <= commit_load;
      frame_err_q <= restart;
    end
  end

  ser_shift_reg #(
    .WIDTH (ADDR_W)
  ) u_addr_sr (
    .clk   (Clk),
    .rst   (Reset),
    .clr   (start_load),
    .shift (start_load | addr_shift),
    .din   (SerIn),
    .load  (commit_load),
    .q     (addr_q),
    .hold  (WrAddr)
  );

  ser_shift_reg #(
    .WIDTH (WIDTH)
  ) u_data_sr (
    .clk   (Clk),
    .rst   (Reset),
    .clr   (start_load),
    .shift (data_shift),
    .din   (SerIn),
    .load  (commit_load),
    .q     (data_q),
    .hold  (WrData)
  );

endmodule

// File: tb/tb_serial_reg_loader.sv
// Directed bench for serial_reg_loader with a frame-level reference model
// checked every cycle plus literal per-scenario expectations.
module tb_serial_reg_loader;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned FBITS  = WIDTH + ADDR_W;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              SerIn = 1'b0;
  logic              SerValid = 1'b0;
  logic              SerStart = 1'b0;
  logic              SerReady;
  logic              WrEn;
  logic [ADDR_W-1:0] WrAddr;
  logic [WIDTH-1:0]  WrData;
  logic              Busy;
  logic              FrameErr;

  int total = 0;
  int bad   = 0;

  serial_reg_loader #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .SerIn    (SerIn),
    .SerValid (SerValid),
    .SerStart (SerStart),
    .SerReady (SerReady),
    .WrEn     (WrEn),
    .WrAddr   (WrAddr),
    .WrData   (WrData),
    .Busy     (Busy),
    .FrameErr (FrameErr)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Frame-level model: a frame is the bit list after a start-flagged beat;
  // once FBITS bits are held, the next cycle is the write cycle.
  int          m_n       = 0;
  logic        m_inframe = 1'b0;
  logic        m_commit  = 1'b0;
  logic        m_err     = 1'b0;
  longint      m_word    = 0;
  int          m_waddr   = 0;
  int          m_wdata   = 0;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_n = 0; m_inframe = 1'b0; m_commit = 1'b0; m_err = 1'b0;
      m_word = 0; m_waddr = 0; m_wdata = 0;
    end else begin
      m_err = 1'b0;
      if (m_commit) begin
        m_commit  = 1'b0;
        m_inframe = 1'b0;
      end else if (SerValid) begin
        if (SerStart) begin
          m_err     = m_inframe;
          m_inframe = 1'b1;
          m_n       = 1;
          m_word    = longint'(SerIn);
        end else if (m_inframe) begin
          m_word = m_word * 2 + longint'(SerIn);
          m_n++;
          if (m_n == FBITS) begin
            m_commit = 1'b1;
            m_waddr  = int'(m_word / (longint'(1) << WIDTH));
            m_wdata  = int'(m_word % (longint'(1) << WIDTH));
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus write/error event tallies.
  int   wr_cnt = 0;
  int   err_cnt = 0;
  int   last_addr = 0;
  int   last_data = 0;

  always @(negedge Clk) begin
    chk("ser_ready", SerReady, !m_commit);
    chk("busy", Busy, m_inframe || m_commit);
    chk("wr_en", WrEn, m_commit);
    chk("frame_err", FrameErr, m_err);
    chk("wr_addr", WrAddr, m_waddr);
    chk("wr_data", WrData, m_wdata);
    if (WrEn) begin
      wr_cnt++;
      last_addr = int'(WrAddr);
      last_data = int'(WrData);
    end
    if (FrameErr) err_cnt++;
  end

  // One beat presented for one clock; caller is at posedge+1.
  task automatic beat(input logic s, input logic b);
    SerValid = 1'b1; SerStart = s; SerIn = b;
    @(posedge Clk); #1;
    SerValid = 1'b0; SerStart = 1'b0; SerIn = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clk); #1;
    end
  endtask

  task automatic send_frame(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d,
                            input bit stall);
    logic [FBITS-1:0] w;
    w = {a, d};
    for (int i = 0; i < int'(FBITS); i++) begin
      beat(i == 0, w[FBITS-1-i]);
      if (stall && (i == 3 || i == 8)) idle(3);
    end
    chk("strobe_after_last_beat", WrEn, 1'b1);
    chk("ready_low_in_commit", SerReady, 1'b0);
  endtask

  int base_wr, base_err;

  initial begin
    // Reset state.
    idle(2);
    chk("rst_wr_en", WrEn, 0);
    chk("rst_wr_addr", WrAddr, 0);
    chk("rst_wr_data", WrData, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_frame_err", FrameErr, 0);
    chk("rst_ser_ready", SerReady, 1);
    Reset = 1'b0;
    idle(2);

    // Basic write: 101 then 10100101.
    base_wr = wr_cnt; base_err = err_cnt;
    send_frame(3'd5, 8'hA5, 1'b0);
    idle(3);
    chk("basic_wr_count", wr_cnt - base_wr, 1);
    chk("basic_addr", last_addr, 5);
    chk("basic_data", last_data, 8'hA5);
    chk("basic_err_count", err_cnt - base_err, 0);

    // Same frame with stalls after beats 4 and 9.
    base_wr = wr_cnt; base_err = err_cnt;
    send_frame(3'd5, 8'hA5, 1'b1);
    idle(3);
    chk("stall_wr_count", wr_cnt - base_wr, 1);
    chk("stall_addr", last_addr, 5);
    chk("stall_data", last_data, 8'hA5);

    // Restart after 6 beats of an unrelated frame.
    base_wr = wr_cnt; base_err = err_cnt;
    beat(1, 0); beat(0, 0); beat(0, 1);
    beat(0, 1); beat(0, 1); beat(0, 1);
    send_frame(3'd2, 8'h3C, 1'b0);
    idle(3);
    chk("restart_err_count", err_cnt - base_err, 1);
    chk("restart_wr_count", wr_cnt - base_wr, 1);
    chk("restart_addr", last_addr, 2);
    chk("restart_data", last_data, 8'h3C);

    // Garbage beats in IDLE without start.
    base_wr = wr_cnt; base_err = err_cnt;
    beat(0, 1); beat(0, 0); beat(0, 1); beat(0, 1); beat(0, 0);
    chk("garbage_not_busy", Busy, 0);
    send_frame(3'd7, 8'hFF, 1'b0);
    idle(3);
    chk("garbage_wr_count", wr_cnt - base_wr, 1);
    chk("garbage_addr", last_addr, 7);
    chk("garbage_data", last_data, 8'hFF);
    chk("garbage_err_count", err_cnt - base_err, 0);

    // Asynchronous reset after data beat 4, mid clock phase.
    base_wr = wr_cnt;
    beat(1, 1); beat(0, 1); beat(0, 0);
    beat(0, 1); beat(0, 1); beat(0, 1); beat(0, 1);
    #2 Reset = 1'b1;
    #1;
    chk("areset_wr_en", WrEn, 0);
    chk("areset_wr_addr", WrAddr, 0);
    chk("areset_wr_data", WrData, 0);
    chk("areset_busy", Busy, 0);
    chk("areset_ser_ready", SerReady, 1);
    @(posedge Clk); #3 Reset = 1'b0;
    @(posedge Clk); #1;
    chk("areset_no_write", wr_cnt - base_wr, 0);
    send_frame(3'd6, 8'h5A, 1'b0);
    idle(3);
    chk("areset_next_wr_count", wr_cnt - base_wr, 1);
    chk("areset_next_addr", last_addr, 6);
    chk("areset_next_data", last_data, 8'h5A);

    // Back-to-back: second start presented during COMMIT, then re-presented.
    base_wr = wr_cnt;
    send_frame(3'd4, 8'h12, 1'b0);
    chk("b2b_first_addr", WrAddr, 4);
    chk("b2b_first_data", WrData, 8'h12);
    beat(1, 0);
    chk("b2b_commit_beat_ignored", Busy, 0);
    send_frame(3'd3, 8'hC3, 1'b0);
    idle(3);
    chk("b2b_wr_count", wr_cnt - base_wr, 2);
    chk("b2b_second_addr", last_addr, 3);
    chk("b2b_second_data", last_data, 8'hC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_reg_loader.md
Name: serial_reg_loader

Overview:
- Bit-serial front end for the register bank built from 1-bit write-enabled register cells. It sits directly upstream of the bank.
- It accepts an address-then-data frame one bit per handshake beat and assembles it into a WIDTH-bit word. It then issues a single-cycle write strobe with the address and data that drive the bank's per-cell write-enable and data inputs.
- The bank holds its value whenever the strobe is low.

Parameters:
- WIDTH, 8, data bits per register word (>=1).
- ADDR_W, 3, register address bits (>=1).

Ports:
- Clk  input  1  single clock; all state updates on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- SerIn  input  1  serial bit, MSB first.
- SerValid  input  1  SerIn is valid this cycle.
- SerStart  input  1  marks the first bit (address MSB) of a frame; qualified by SerValid.
- SerReady  output  1  loader accepts a bit this cycle.
- WrEn  output  1  one-cycle write strobe to the register bank.
- WrAddr  output  ADDR_W  target register address.
- WrData  output  WIDTH  word to write.
- Busy  output  1  a frame is in progress (ADDR, DATA or COMMIT state).
- FrameErr  output  1  one-cycle pulse when a frame is aborted by a restart.

Behaviour:
- Reset (async, any time, including mid-frame):
  - State goes to IDLE; the shift register and bit counter clear.
  - WrEn=0, WrAddr=0, WrData=0, Busy=0, FrameErr=0, SerReady=1.
  - No partial write is ever issued.
- Beat definition: a beat occurs when SerValid & SerReady.
- SerReady: 1 in IDLE, ADDR and DATA; 0 in COMMIT.
- IDLE:
  - A beat with SerStart=1 captures SerIn as the address MSB.
  - Next state is ADDR if ADDR_W>1, else DATA.
  - A beat with SerStart=0 is discarded silently; no error is flagged.
- ADDR: each beat shifts SerIn into the address register. After ADDR_W address bits in total, next state is DATA.
- DATA: each beat shifts SerIn into the data register. The beat carrying the WIDTH-th data bit moves the state to COMMIT.
- COMMIT (exactly one cycle):
  - WrEn=1; WrAddr and WrData present the assembled frame.
  - Next state is IDLE.
- Latency: the last data beat is in cycle N, WrEn is high in cycle N+1, and SerReady returns to 1 in cycle N+2.
- Output hold: WrEn, WrAddr and WrData are registered. WrAddr and WrData hold the last committed value until the next COMMIT; they never show a partially shifted frame.
- Restart: a beat with SerStart=1 while in ADDR or DATA aborts the current frame.
  - FrameErr pulses high the next cycle.
  - The new bit becomes the address MSB and the counter reloads.
  - No WrEn is issued for the aborted frame.
- SerStart=1 on the last data beat counts as a restart, not a completion.
- Bit counter: width $clog2(max(ADDR_W,WIDTH)+1). It counts down per beat and reloads at the ADDR-to-DATA transition. There is no wrap-around; the terminal count forces the state transition.
- Stalls: SerValid=0 in any state other than COMMIT holds all state indefinitely.
- Busy=1 in ADDR, DATA and COMMIT; 0 in IDLE.

Decomposition:
- Shared package holds:
  - state encoding typedef {IDLE, ADDR, DATA, COMMIT};
  - default WIDTH and ADDR_W constants, reused by the register bank.
- One sub-module, ser_shift_reg: a parameterised WIDTH-bit MSB-first shift register with shift-enable and clear.
  - Instantiated twice, once for address and once for data.
  - The FSM and counter live in the top module.

Test Plan:
- Basic write (WIDTH=8, ADDR_W=3): 11 back-to-back beats with SerStart on the first, bits 101 then 10100101.
  - WrEn high exactly 1 cycle, one cycle after beat 11; WrAddr=3'd5; WrData=8'hA5; FrameErr=0.
- Stalled frame: same frame with SerValid deasserted for 3 cycles after beat 4 and after beat 9.
  - Identical result; no WrEn during stalls; Busy=1 throughout.
- Restart: 6 beats of a frame, then a beat with SerStart=1 followed by a full frame addr 3'd2, data 8'h3C.
  - FrameErr pulses once; exactly one WrEn with WrAddr=2, WrData=8'h3C.
- Idle garbage: 5 beats with SerStart=0 in IDLE, then a valid frame addr 7, data 8'hFF.
  - Garbage ignored; single write with WrAddr=7, WrData=8'hFF.
- Reset mid-frame: Reset asserted asynchronously (not clock-aligned) after data beat 4.
  - Outputs immediately 0; SerReady=1; no WrEn; the next full frame writes correctly.
- Back-to-back frames: second SerStart beat presented in the COMMIT cycle.
  - Not accepted (SerReady=0); accepted the following cycle; two WrEn pulses, the second with the correct second word.
